// File: rtl/uart_tx_arb_if.sv
// Byte handshake bundle between the requesters, the arbiter and the UART
// transmitter byte port. The slave modport is the arbiter's view.
interface uart_tx_arb_if #(
   parameter int NREQ = 2
);
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   req_ready;
   logic              tx_valid;
   logic [7:0]        tx_data;
   logic              tx_ready;

   modport master (
      output req_valid, req_data, req_last, tx_ready,
      input  req_ready, tx_valid, tx_data
   );

   modport slave (
      input  req_valid, req_data, req_last, tx_ready,
      output req_ready, tx_valid, tx_data
   );
endinterface

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter sharing one UART TX byte port among NREQ
// requesters. A grant is held until the owner delivers a byte flagged last.
// Optional watchdog: define UART_ARB_TIMEOUT_EN to revoke a grant whose owner
// has been idle (req_valid low) for TIMEOUT cycles.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no owner; pick next requester round-robin from last_grant+1
// S_GRANT | grant_id owns the transmitter; bytes pass through unregistered
module uart_tx_arb #(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 1024
) (
   input  logic          clk,
   input  logic          reset,
   uart_tx_arb_if.slave  bus,
   output logic          busy,
   output logic [1:0]    grant_id,
   output logic          timeout_flag
);
   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t      state, state_nxt;
   logic [1:0]  last_grant;
   logic [1:0]  pick;
   logic [3:0]  valid_pad;
   logic [3:0]  last_pad;
   logic [31:0] data_pad;
   logic        any_req;
   logic        xfer;
   logic        last_beat;
   logic        revoke;

   // Widen request vectors to the 4-requester maximum so a 2-bit grant_id
   // always indexes cleanly whatever NREQ is.
   assign valid_pad = 4'(bus.req_valid);
   assign last_pad  = 4'(bus.req_last);
   assign data_pad  = 32'(bus.req_data);
   assign any_req   = |bus.req_valid;
   assign xfer      = bus.tx_valid & bus.tx_ready;
   assign last_beat = xfer & last_pad[grant_id];

   // Round-robin scan: first valid requester after last_grant, wrapping.
   always_comb begin : pick_scan
      logic [1:0] idx;
      logic       found;
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = 2'((int'(last_grant) + k) % NREQ);
         if (!found && valid_pad[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; a last beat or a watchdog revoke ends the grant.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (any_req) state_nxt = S_GRANT;
         S_GRANT: if (last_beat || revoke) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs: combinational pass-through of the owner's byte, zero data when idle.
   always_comb begin
      busy          = (state == S_GRANT);
      bus.tx_valid  = 1'b0;
      bus.tx_data   = '0;
      bus.req_ready = '0;
      if (state == S_GRANT) begin
         bus.tx_valid = valid_pad[grant_id];
         if (valid_pad[grant_id]) bus.tx_data = data_pad[{grant_id, 3'b000} +: 8];
         for (int i = 0; i < NREQ; i++) begin
            bus.req_ready[i] = (grant_id == 2'(i)) & bus.tx_ready;
         end
      end
   end

   // Grant bookkeeping: latch the winner on grant, remember it on release.
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_id   <= '0;
         last_grant <= 2'(NREQ - 1);
      end else if (state == S_IDLE && any_req) begin
         grant_id <= pick;
      end else if (state == S_GRANT && (last_beat || revoke)) begin
         last_grant <= grant_id;
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] idle_cnt;
   logic             stalled;

   // Owner idle; a stalled tx_ready with valid high never counts.
   assign stalled = (state == S_GRANT) && !valid_pad[grant_id];
   // Stalled implies no transfer, so a last beat always wins over revoke.
   assign revoke  = stalled && (idle_cnt == CNT_W'(TIMEOUT - 1));

   // Watchdog counter and sticky revoke flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         idle_cnt     <= '0;
         timeout_flag <= 1'b0;
      end else begin
         if (!stalled || revoke) idle_cnt <= '0;
         else                    idle_cnt <= idle_cnt + 1'b1;
         if (revoke) timeout_flag <= 1'b1;
      end
   end
`else
   logic unused_timeout;

   assign unused_timeout = ^TIMEOUT;
   assign revoke         = 1'b0;
   assign timeout_flag   = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb (NREQ=2, TIMEOUT=16): directed scenarios followed by
// random packets, all checked every cycle against a transaction-level model
// (owner / last winner / idle count) plus explicit byte-order checks.
module tb_uart_tx_arb;
   localparam int N       = 2;
   localparam int TIMEOUT = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       busy;
   logic [1:0] gid;
   logic       tflag;

   uart_tx_arb_if #(.NREQ(N)) bus ();

   uart_tx_arb #(.NREQ(N), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .reset        (rst),
      .bus          (bus.slave),
      .busy         (busy),
      .grant_id     (gid),
      .timeout_flag (tflag)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Requester byte queues: {last, data}; the front byte is what is offered.
   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [7:0] xlog[$];

   // Reference model state.
   int         own     = -1;
   int         m_gid   = 0;
   int         m_last  = N - 1;
   int         m_idle  = 0;
   logic       m_tflag = 1'b0;
   logic [1:0] acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      bus.req_valid[0]   = (q0.size() > 0);
      bus.req_valid[1]   = (q1.size() > 0);
      bus.req_data[7:0]  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
      bus.req_data[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
      bus.req_last[0]    = (q0.size() > 0) ? q0[0][8] : 1'b0;
      bus.req_last[1]    = (q1.size() > 0) ? q1[0][8] : 1'b0;
   endtask

   task automatic check_outputs();
      logic [1:0]  v;
      logic [15:0] d;
      logic        e_tv;
      logic [7:0]  e_td;
      logic [1:0]  e_rr;
      v = bus.req_valid;
      d = bus.req_data;
      e_tv = 1'b0;
      e_td = 8'h00;
      e_rr = 2'b00;
      if (own >= 0) begin
         e_tv = v[own];
         e_rr[own] = bus.tx_ready;
         if (e_tv) e_td = d[own*8 +: 8];
      end
      chk("tx_valid", 32'(bus.tx_valid), 32'(e_tv));
      chk("tx_data", 32'(bus.tx_data), 32'(e_td));
      chk("req_ready", 32'(bus.req_ready), 32'(e_rr));
      chk("busy", 32'(busy), 32'(own >= 0));
      chk("grant_id", 32'(gid), 32'(m_gid));
      chk("timeout_flag", 32'(tflag), 32'(m_tflag));
      if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) xlog.push_back(bus.tx_data);
   endtask

   task automatic advance_model();
      logic [1:0] v;
      logic [1:0] l;
      int         c;
      v = bus.req_valid;
      l = bus.req_last;
      acc = 2'b00;
      if (rst) begin
         own = -1; m_gid = 0; m_last = N - 1; m_idle = 0; m_tflag = 1'b0;
      end else if (own < 0) begin
         m_idle = 0;
         for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (own < 0 && v[c]) begin
               own   = c;
               m_gid = c;
            end
         end
      end else if (v[own]) begin
         m_idle = 0;
         if (bus.tx_ready) begin
            acc[own] = 1'b1;
            if (l[own]) begin
               m_last = own;
               own    = -1;
            end
         end
      end else begin
`ifdef UART_ARB_TIMEOUT_EN
         if (m_idle == TIMEOUT - 1) begin
            m_last = own; own = -1; m_tflag = 1'b1; m_idle = 0;
         end else begin
            m_idle++;
         end
`endif
      end
   endtask

   task automatic cycle();
      drive();
      #1;
      check_outputs();
      advance_model();
      if (acc[0]) void'(q0.pop_front());
      if (acc[1]) void'(q1.pop_front());
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset();
      q0.delete();
      q1.delete();
      drive();
      bus.tx_ready = 1'b1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      own = -1; m_gid = 0; m_last = N - 1; m_idle = 0; m_tflag = 1'b0;
   endtask

   task automatic expect_byte(input string tag, input logic [7:0] e);
      logic [31:0] o;
      o = 32'hFFFF_FFFF;
      if (xlog.size() > 0) o = 32'(xlog.pop_front());
      chk(tag, o, 32'(e));
   endtask

   initial begin
      bus.tx_ready = 1'b1;
      do_reset();

      // Reset values with no requests pending.
      #1;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("reset_tx_data", 32'(bus.tx_data), 32'd0);
      chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
      chk("reset_grant_id", 32'(gid), 32'd0);
      chk("reset_timeout_flag", 32'(tflag), 32'd0);
      @(negedge clk);

      // Test 1: single requester, three-byte packet.
      xlog.delete();
      q0.push_back({1'b0, 8'h41});
      q0.push_back({1'b0, 8'h42});
      q0.push_back({1'b1, 8'h43});
      run(5);
      expect_byte("t1_b0", 8'h41);
      expect_byte("t1_b1", 8'h42);
      expect_byte("t1_b2", 8'h43);
      chk("t1_busy_low", 32'(busy), 32'd0);
      chk("t1_grant_id", 32'(gid), 32'd0);

      // Test 2: simultaneous requests from reset, two rounds.
      do_reset();
      xlog.delete();
      q0.push_back({1'b0, 8'hA0}); q0.push_back({1'b1, 8'hA1});
      q0.push_back({1'b0, 8'hA2}); q0.push_back({1'b1, 8'hA3});
      q1.push_back({1'b0, 8'hB0}); q1.push_back({1'b1, 8'hB1});
      q1.push_back({1'b0, 8'hB2}); q1.push_back({1'b1, 8'hB3});
      run(14);
      expect_byte("t2_b0", 8'hA0); expect_byte("t2_b1", 8'hA1);
      expect_byte("t2_b2", 8'hB0); expect_byte("t2_b3", 8'hB1);
      expect_byte("t2_b4", 8'hA2); expect_byte("t2_b5", 8'hA3);
      expect_byte("t2_b6", 8'hB2); expect_byte("t2_b7", 8'hB3);

      // Test 3: requester 0 arrives while requester 1 is mid-packet.
      xlog.delete();
      q1.push_back({1'b0, 8'hC0}); q1.push_back({1'b0, 8'hC1}); q1.push_back({1'b1, 8'hC2});
      run(2);
      chk("t3_grant_id", 32'(gid), 32'd1);
      q0.push_back({1'b0, 8'hD0}); q0.push_back({1'b1, 8'hD1});
      run(6);
      expect_byte("t3_b0", 8'hC0); expect_byte("t3_b1", 8'hC1);
      expect_byte("t3_b2", 8'hC2); expect_byte("t3_b3", 8'hD0);
      expect_byte("t3_b4", 8'hD1);

      // Test 4: transmitter stalled for 20 cycles on a single-byte packet.
      xlog.delete();
      bus.tx_ready = 1'b0;
      q0.push_back({1'b1, 8'h55});
      run(21);
      chk("t4_no_xfer", 32'(xlog.size()), 32'd0);
      bus.tx_ready = 1'b1;
      run(2);
      chk("t4_one_xfer", 32'(xlog.size()), 32'd1);
      expect_byte("t4_b0", 8'h55);

      // Test 5: reset in the middle of a four-byte packet.
      xlog.delete();
      q1.push_back({1'b0, 8'h01});
      run(2);
      q1.push_back({1'b1, 8'h02});
      run(2);
      q0.push_back({1'b0, 8'hE0}); q0.push_back({1'b0, 8'hE1});
      q0.push_back({1'b0, 8'hE2}); q0.push_back({1'b1, 8'hE3});
      run(3);
      chk("t5_mid_grant", 32'(gid), 32'd0);
      rst = 1'b1;
      bus.tx_ready = 1'b0;
      cycle();
      rst = 1'b0;
      bus.tx_ready = 1'b1;
      q0.delete();
      drive();
      #1;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("t5_grant_id", 32'(gid), 32'd0);
      @(negedge clk);
      q1.push_back({1'b1, 8'hF0});
      q0.push_back({1'b1, 8'hF1});
      run(5);
      expect_byte("t5_b0", 8'h01); expect_byte("t5_b1", 8'h02);
      expect_byte("t5_b2", 8'hE0); expect_byte("t5_b3", 8'hE1);
      expect_byte("t5_b4", 8'hF1); expect_byte("t5_b5", 8'hF0);

      // Test 6: owner drops valid mid-packet while requester 1 waits.
      xlog.delete();
      q0.push_back({1'b0, 8'h10});
      q1.push_back({1'b1, 8'h20});
      run(20);
`ifdef UART_ARB_TIMEOUT_EN
      chk("t6_timeout_flag", 32'(tflag), 32'd1);
      expect_byte("t6_b0", 8'h10);
      expect_byte("t6_b1", 8'h20);
`else
      chk("t6_busy_held", 32'(busy), 32'd1);
      chk("t6_grant_held", 32'(gid), 32'd0);
      chk("t6_timeout_flag", 32'(tflag), 32'd0);
      expect_byte("t6_b0", 8'h10);
      chk("t6_no_more", 32'(xlog.size()), 32'd0);
`endif
      q0.push_back({1'b1, 8'h11});
      run(6);
      chk("t6_q0_done", 32'(q0.size()), 32'd0);
      chk("t6_q1_done", 32'(q1.size()), 32'd0);

      // Random phase: random packets and transmitter back-pressure.
      for (int cyc = 0; cyc < 1500; cyc++) begin
         int len;
         bus.tx_ready = ($urandom_range(0, 3) != 0);
         if (q0.size() < 3 && $urandom_range(0, 5) == 0) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) q0.push_back({(b == len - 1), 8'($urandom)});
         end
         if (q1.size() < 3 && $urandom_range(0, 5) == 0) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) q1.push_back({(b == len - 1), 8'($urandom)});
         end
         cycle();
      end

      // Drain with a bounded wait.
      bus.tx_ready = 1'b1;
      for (int i = 0; i < 300 && (q0.size() > 0 || q1.size() > 0 || own >= 0); i++) cycle();
      chk("drain_q0_empty", 32'(q0.size()), 32'd0);
      chk("drain_q1_empty", 32'(q1.size()), 32'd0);
      chk("drain_busy", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
